// File: rtl/apb4_rtc_prescaler_pkg.sv
// Shared definitions for the APB4 RTC prescaler: register map, CTRL layout, bus widths.
package apb4_rtc_prescaler_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;

    localparam logic [3:0] REG_CTRL = 4'h0;
    localparam logic [3:0] REG_PSCR = 4'h1;
    localparam logic [3:0] REG_CNT  = 4'h2;
    localparam logic [3:0] REG_STAT = 4'h3;

    localparam int unsigned CTRL_EN_BIT  = 0;
    localparam int unsigned CTRL_SRC_BIT = 1;

    typedef struct packed {
        logic src;
        logic en;
    } ctrl_t;

    // CTRL readback: only EN and SRC are implemented, upper bits read 0
    function automatic logic [DATA_W-1:0] ctrl_to_word(input ctrl_t c);
        return {{(DATA_W-2){1'b0}}, c};
    endfunction

endpackage

// File: rtl/rtc_psc_core.sv
// Divider core: counts source events up to div and toggles the tick level on wrap.
module rtc_psc_core
    import apb4_rtc_prescaler_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 evt,
    input  logic                 en,
    input  logic                 clr,
    input  logic [DIV_WIDTH-1:0] div,
    output logic [DIV_WIDTH-1:0] cnt,
    output logic                 tick
);

    // Priority: disable, then reconfiguration clear, then event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (!en) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
        end else if (evt) begin
            if (cnt == div) begin
                cnt  <= '0;
                tick <= ~tick;
            end else begin
                cnt  <= cnt + DIV_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/apb4_rtc_prescaler.sv
// APB4-configured RTC tick generator feeding the CLINT rtc_clk_i; divides hclk or a
// synchronised external slow clock.
module apb4_rtc_prescaler
    import apb4_rtc_prescaler_pkg::*;
#(
    parameter int unsigned DIV_WIDTH = 16,
    parameter int unsigned DIV_RST   = 49
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic [ADDR_W-1:0] paddr,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [DATA_W-1:0] pwdata,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              rtc_ext_i,
    output logic              rtc_clk_o
);

    logic [3:0]           reg_idx;
    logic                 wr_en;
    logic                 wr_ctrl;
    logic                 wr_pscr;
    ctrl_t                wr_ctrl_val;
    ctrl_t                ctrl_q;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] cnt;
    logic                 ext_sync1;
    logic                 ext_sync2;
    logic                 ext_prev;
    logic                 ext_rise;
    logic                 src_evt;
    logic                 core_en;
    logic                 core_clr;
    logic                 unused_bits;

    assign reg_idx     = paddr[5:2];
    assign wr_en       = psel & penable & pwrite;
    assign wr_ctrl     = wr_en && (reg_idx == REG_CTRL);
    assign wr_pscr     = wr_en && (reg_idx == REG_PSCR);
    assign wr_ctrl_val = '{src: pwdata[CTRL_SRC_BIT], en: pwdata[CTRL_EN_BIT]};

    assign pready      = 1'b1;
    assign pslverr     = 1'b0;
    assign unused_bits = ^{paddr[ADDR_W-1:6], paddr[1:0], pwdata};

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ctrl_q <= '0;
        end else if (wr_ctrl) begin
            ctrl_q <= wr_ctrl_val;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            div_q <= DIV_WIDTH'(DIV_RST);
        end else if (wr_pscr) begin
            div_q <= pwdata[DIV_WIDTH-1:0];
        end
    end

    // Two-flop synchroniser plus rising-edge detector for the external clock
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            ext_sync1 <= 1'b0;
            ext_sync2 <= 1'b0;
            ext_prev  <= 1'b0;
        end else begin
            ext_sync1 <= rtc_ext_i;
            ext_sync2 <= ext_sync1;
            ext_prev  <= ext_sync2;
        end
    end

    assign ext_rise = ext_sync2 & ~ext_prev;
    assign src_evt  = ctrl_q.src ? ext_rise : 1'b1;

    // A write clearing EN takes effect at the write edge, overriding any coincident event
    assign core_en  = ctrl_q.en & ~(wr_ctrl & ~wr_ctrl_val.en);
    assign core_clr = wr_pscr | (wr_ctrl & (wr_ctrl_val.src != ctrl_q.src));

    rtc_psc_core #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_core (
        .clk  (hclk),
        .rst_n(hresetn),
        .evt  (src_evt),
        .en   (core_en),
        .clr  (core_clr),
        .div  (div_q),
        .cnt  (cnt),
        .tick (rtc_clk_o)
    );

    always_comb begin
        prdata = '0;
        case (reg_idx)
            REG_CTRL: prdata = ctrl_to_word(ctrl_q);
            REG_PSCR: prdata = DATA_W'(div_q);
            REG_CNT:  prdata = DATA_W'(cnt);
            REG_STAT: prdata = DATA_W'(rtc_clk_o);
            default:  prdata = '0;
        endcase
    end

endmodule

// File: tb/tb_apb4_rtc_prescaler.sv
// Directed self-checking bench for apb4_rtc_prescaler; rtc_clk_o rising edges model mtime.
module tb_apb4_rtc_prescaler;
    import apb4_rtc_prescaler_pkg::*;

    logic              hclk = 1'b0;
    logic              hresetn = 1'b0;
    logic [ADDR_W-1:0] paddr = '0;
    logic              psel = 1'b0;
    logic              penable = 1'b0;
    logic              pwrite = 1'b0;
    logic [DATA_W-1:0] pwdata = '0;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;
    logic              rtc_ext_i = 1'b0;
    logic              rtc_clk_o;

    int total = 0;
    int bad   = 0;
    int mtime = 0;

    apb4_rtc_prescaler #(.DIV_WIDTH(16), .DIV_RST(49)) dut (
        .hclk     (hclk),
        .hresetn  (hresetn),
        .paddr    (paddr),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .pwdata   (pwdata),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .rtc_ext_i(rtc_ext_i),
        .rtc_clk_o(rtc_clk_o)
    );

    always #5 hclk = ~hclk;

    always @(posedge rtc_clk_o) mtime++;

    // Called at a negedge; the write lands on the second following posedge
    task automatic apb_write(input logic [3:0] idx, input logic [31:0] data);
        paddr   = ADDR_W'({idx, 2'b00});
        pwdata  = data;
        pwrite  = 1'b1;
        psel    = 1'b1;
        penable = 1'b0;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
    endtask

    // Called at a negedge; returns the register state as of the call
    task automatic apb_read(input logic [3:0] idx, output logic [31:0] data, output logic err);
        paddr   = ADDR_W'({idx, 2'b00});
        pwrite  = 1'b0;
        psel    = 1'b1;
        penable = 1'b0;
        #1;
        data = prdata;
        err  = pslverr;
        @(negedge hclk);
        penable = 1'b1;
        @(negedge hclk);
        psel    = 1'b0;
        penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [3:0]  idx [5] = '{REG_CTRL, REG_PSCR, REG_CNT, REG_STAT, 4'h5};
        logic [31:0] exp [5] = '{32'd0, 32'd49, 32'd0, 32'd0, 32'd0};
        logic [31:0] d;
        logic        e;
        hresetn = 1'b0;
        repeat (3) @(negedge hclk);
        hresetn = 1'b1;
        repeat (20) @(negedge hclk);
        total++;
        if (rtc_clk_o !== 1'b0) begin bad++; $display("FAIL reset_rtc got=%b want=0", rtc_clk_o); end
        total++;
        if (pready !== 1'b1) begin bad++; $display("FAIL reset_pready got=%b want=1", pready); end
        for (int i = 0; i < 5; i++) begin
            apb_read(idx[i], d, e);
            total++;
            if (d !== exp[i]) begin bad++; $display("FAIL reset_reg%0d got=%0h want=%0h", i, d, exp[i]); end
            total++;
            if (e !== 1'b0) begin bad++; $display("FAIL reset_pslverr%0d got=%b want=0", i, e); end
        end
    endtask

    task automatic test_hclk_div();
        int   rises [$];
        logic prev;
        logic expv;
        apb_write(REG_PSCR, 32'd0);
        apb_write(REG_CTRL, 32'd1);
        for (int i = 0; i < 8; i++) begin
            expv = (i % 2) == 1;
            total++;
            if (rtc_clk_o !== expv) begin bad++; $display("FAIL div0_toggle%0d got=%b want=%b", i, rtc_clk_o, expv); end
            @(negedge hclk);
        end
        apb_write(REG_PSCR, 32'd3);
        prev = rtc_clk_o;
        for (int c = 1; c <= 60 && rises.size() < 3; c++) begin
            @(negedge hclk);
            if (rtc_clk_o && !prev) rises.push_back(c);
            prev = rtc_clk_o;
        end
        total++;
        if (rises.size() != 3) begin
            bad++; $display("FAIL div3_rises got=%0d want=3", rises.size());
        end else begin
            total++;
            if (rises[1] - rises[0] != 8) begin bad++; $display("FAIL div3_period_a got=%0d want=8", rises[1] - rises[0]); end
            total++;
            if (rises[2] - rises[1] != 8) begin bad++; $display("FAIL div3_period_b got=%0d want=8", rises[2] - rises[1]); end
        end
    endtask

    task automatic test_ext_src();
        int   rises [$];
        logic prev;
        apb_write(REG_CTRL, 32'd0);
        apb_write(REG_PSCR, 32'd1);
        apb_write(REG_CTRL, 32'd3);
        prev = rtc_clk_o;
        for (int c = 0; c < 100; c++) begin
            if (rtc_clk_o && !prev) rises.push_back(c);
            prev = rtc_clk_o;
            rtc_ext_i = (c % 10) < 5;
            @(negedge hclk);
        end
        rtc_ext_i = 1'b0;
        total++;
        if (rises.size() != 3) begin
            bad++; $display("FAIL ext_rises got=%0d want=3", rises.size());
        end else begin
            total++;
            if (rises[0] != 13) begin bad++; $display("FAIL ext_first got=%0d want=13", rises[0]); end
            total++;
            if (rises[1] - rises[0] != 40) begin bad++; $display("FAIL ext_period got=%0d want=40", rises[1] - rises[0]); end
        end
        repeat (5) @(negedge hclk);
        apb_write(REG_CTRL, 32'd0);
    endtask

    task automatic test_div_rewrite();
        logic [31:0] d;
        logic        e;
        apb_write(REG_PSCR, 32'd7);
        apb_write(REG_CTRL, 32'd1);
        repeat (12) @(negedge hclk);
        total++;
        if (rtc_clk_o !== 1'b1) begin bad++; $display("FAIL rw_pre got=%b want=1", rtc_clk_o); end
        apb_write(REG_PSCR, 32'd2);
        total++;
        if (rtc_clk_o !== 1'b1) begin bad++; $display("FAIL rw_hold got=%b want=1", rtc_clk_o); end
        apb_read(REG_CNT, d, e);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL rw_cnt got=%0d want=0", d); end
        total++;
        if (rtc_clk_o !== 1'b1) begin bad++; $display("FAIL rw_two_events got=%b want=1", rtc_clk_o); end
        @(negedge hclk);
        total++;
        if (rtc_clk_o !== 1'b0) begin bad++; $display("FAIL rw_third_event got=%b want=0", rtc_clk_o); end
        @(negedge hclk);
        apb_write(REG_PSCR, 32'd2);
        total++;
        if (rtc_clk_o !== 1'b0) begin bad++; $display("FAIL rw_coincident got=%b want=0", rtc_clk_o); end
        apb_read(REG_CNT, d, e);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL rw_coincident_cnt got=%0d want=0", d); end
    endtask

    task automatic test_en_clear();
        logic [31:0] d;
        logic        e;
        int          first;
        @(negedge hclk);
        total++;
        if (rtc_clk_o !== 1'b1) begin bad++; $display("FAIL en_pre got=%b want=1", rtc_clk_o); end
        apb_write(REG_CTRL, 32'd0);
        total++;
        if (rtc_clk_o !== 1'b0) begin bad++; $display("FAIL en_clear_rtc got=%b want=0", rtc_clk_o); end
        apb_read(REG_CNT, d, e);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL en_clear_cnt got=%0d want=0", d); end
        apb_write(REG_CTRL, 32'd1);
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge hclk);
            if (rtc_clk_o === 1'b1 && first == 0) first = i;
        end
        total++;
        if (first != 3) begin bad++; $display("FAIL en_restart got=%0d want=3", first); end
    endtask

    task automatic test_mtime_reset();
        logic [31:0] d;
        logic        e;
        int          m0;
        apb_write(REG_CTRL, 32'd0);
        apb_write(REG_PSCR, 32'd4);
        apb_write(REG_CTRL, 32'd1);
        m0 = mtime;
        repeat (100) @(negedge hclk);
        total++;
        if (mtime - m0 != 10) begin bad++; $display("FAIL mtime_advance got=%0d want=10", mtime - m0); end
        repeat (7) @(negedge hclk);
        total++;
        if (rtc_clk_o !== 1'b1) begin bad++; $display("FAIL mtime_pre_reset got=%b want=1", rtc_clk_o); end
        m0 = mtime;
        hresetn = 1'b0;
        #1;
        total++;
        if (rtc_clk_o !== 1'b0) begin bad++; $display("FAIL async_reset_rtc got=%b want=0", rtc_clk_o); end
        repeat (5) @(negedge hclk);
        hresetn = 1'b1;
        @(negedge hclk);
        total++;
        if (mtime != m0) begin bad++; $display("FAIL async_reset_mtime got=%0d want=%0d", mtime, m0); end
        apb_read(REG_CTRL, d, e);
        total++;
        if (d !== 32'd0) begin bad++; $display("FAIL async_reset_ctrl got=%0h want=0", d); end
        apb_read(REG_PSCR, d, e);
        total++;
        if (d !== 32'd49) begin bad++; $display("FAIL async_reset_pscr got=%0d want=49", d); end
    endtask

    task automatic test_ext_high_at_reset();
        int m0;
        rtc_ext_i = 1'b1;
        hresetn = 1'b0;
        @(negedge hclk);
        hresetn = 1'b1;
        apb_write(REG_PSCR, 32'd0);
        apb_write(REG_CTRL, 32'd3);
        m0 = mtime;
        repeat (10) @(negedge hclk);
        total++;
        if (rtc_clk_o !== 1'b0) begin bad++; $display("FAIL ext_high_rtc got=%b want=0", rtc_clk_o); end
        total++;
        if (mtime != m0) begin bad++; $display("FAIL ext_high_mtime got=%0d want=%0d", mtime, m0); end
        rtc_ext_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hclk_div();
        test_ext_src();
        test_div_rewrite();
        test_en_clear();
        test_mtime_reset();
        test_ext_high_at_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
